// File: rtl/tl_xing_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_xing_arbiter_pkg
// Description : Shared widths, requester count and tracker state encoding for
//               the two-requester TileLink crossing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_xing_arbiter_pkg;

    localparam int unsigned N_REQ    = 2;
    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PARAM_W  = 2;
    localparam int unsigned SIZE_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } trk_state_e;

endpackage
`default_nettype wire

// File: rtl/tl_xing_req_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tl_xing_req_tracker
// Description : Per-requester outstanding tracker with saturating wait
//               counter and sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_xing_req_tracker
    import tl_xing_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic a_fire,
    input  logic d_fire,
    input  logic err_clear,
    output logic busy,
    output logic err_timeout
);

    localparam logic [15:0] TIMEOUT_VAL = TIMEOUT_CYCLES[15:0];

    trk_state_e  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        timeout_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // The flag fires only on the increment that lands on the threshold, so a
    // counter parked at 0xFFFF cannot re-assert it after a clear.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;
        if (state_q == IDLE) begin
            if (a_fire) begin
                state_d    = BUSY;
                wait_cnt_d = '0;
            end
        end else begin
            if (wait_cnt_q != 16'hFFFF) begin
                wait_cnt_d  = wait_cnt_q + 16'd1;
                timeout_set = (wait_cnt_d == TIMEOUT_VAL);
            end
            if (d_fire) begin
                state_d = IDLE;
            end
        end
        timeout_d = timeout_set | (timeout_q & ~err_clear);
    end

    assign busy        = (state_q == BUSY);
    assign err_timeout = timeout_q;

endmodule
`default_nettype wire

// File: rtl/tl_xing_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tl_xing_arbiter
// Description : Round-robin arbiter merging two TileLink requesters onto one
//               async-crossing port, with D-channel routing and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_xing_arbiter
    import tl_xing_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_a_valid,
    output logic [N_REQ-1:0]            req_a_ready,
    input  logic [N_REQ*OPCODE_W-1:0]   req_a_opcode,
    input  logic [N_REQ*ADDR_W-1:0]     req_a_address,
    input  logic [N_REQ*DATA_W-1:0]     req_a_data,
    output logic [N_REQ-1:0]            req_d_valid,
    input  logic [N_REQ-1:0]            req_d_ready,
    output logic [OPCODE_W-1:0]         req_d_opcode,
    output logic [PARAM_W-1:0]          req_d_param,
    output logic [SIZE_W-1:0]           req_d_size,
    output logic                        req_d_sink,
    output logic                        req_d_denied,
    output logic [DATA_W-1:0]           req_d_data,
    output logic                        req_d_corrupt,
    output logic                        out_a_valid,
    input  logic                        out_a_ready,
    output logic [OPCODE_W-1:0]         out_a_opcode,
    output logic [ADDR_W-1:0]           out_a_address,
    output logic [DATA_W-1:0]           out_a_data,
    output logic                        out_a_source,
    input  logic                        out_d_valid,
    output logic                        out_d_ready,
    input  logic [OPCODE_W-1:0]         out_d_opcode,
    input  logic [PARAM_W-1:0]          out_d_param,
    input  logic [SIZE_W-1:0]           out_d_size,
    input  logic                        out_d_source,
    input  logic                        out_d_sink,
    input  logic                        out_d_denied,
    input  logic [DATA_W-1:0]           out_d_data,
    input  logic                        out_d_corrupt,
    output logic [N_REQ-1:0]            err_timeout,
    output logic                        err_unexpected_d,
    input  logic                        err_clear
);

    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] d_fire;
    logic             grant;
    logic             a_fire;
    logic             d_tgt_busy;
    logic             ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic             lock_idx_q, lock_idx_d;
    logic             unexp_q, unexp_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            unexp_q    <= unexp_d;
        end
    end

    // A-side: a stalled offer keeps its grant even if the holder drops valid.
    always_comb begin
        eligible = req_a_valid & ~busy;
        grant    = ptr_q;
        if (lock_q) begin
            grant = lock_idx_q;
        end else if (eligible[ptr_q]) begin
            grant = ptr_q;
        end else if (eligible[~ptr_q]) begin
            grant = ~ptr_q;
        end
        out_a_valid   = ~reset & (lock_q | (|eligible));
        a_fire        = out_a_valid & out_a_ready;
        req_a_ready   = a_fire ? (grant ? 2'b10 : 2'b01) : 2'b00;
        out_a_source  = grant;
        out_a_opcode  = grant ? req_a_opcode[OPCODE_W +: OPCODE_W] : req_a_opcode[0 +: OPCODE_W];
        out_a_address = grant ? req_a_address[ADDR_W +: ADDR_W]    : req_a_address[0 +: ADDR_W];
        out_a_data    = grant ? req_a_data[DATA_W +: DATA_W]       : req_a_data[0 +: DATA_W];
        lock_d        = out_a_valid & ~out_a_ready;
        lock_idx_d    = grant;
        ptr_d         = a_fire ? ~grant : ptr_q;
    end

    // D-side: beats for an idle tracker are swallowed and flagged.
    always_comb begin
        d_tgt_busy  = busy[out_d_source];
        out_d_ready = reset | ~d_tgt_busy | req_d_ready[out_d_source];
        if (reset | ~out_d_valid | ~d_tgt_busy) begin
            req_d_valid = 2'b00;
        end else begin
            req_d_valid = out_d_source ? 2'b10 : 2'b01;
        end
        d_fire  = out_d_ready ? req_d_valid : 2'b00;
        unexp_d = (out_d_valid & ~d_tgt_busy) | (unexp_q & ~err_clear);
    end

    assign req_d_opcode     = out_d_opcode;
    assign req_d_param      = out_d_param;
    assign req_d_size       = out_d_size;
    assign req_d_sink       = out_d_sink;
    assign req_d_denied     = out_d_denied;
    assign req_d_data       = out_d_data;
    assign req_d_corrupt    = out_d_corrupt;
    assign err_unexpected_d = unexp_q;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_trk
            tl_xing_req_tracker #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_trk (
                .clock       (clock),
                .reset       (reset),
                .a_fire      (req_a_ready[gi]),
                .d_fire      (d_fire[gi]),
                .err_clear   (err_clear),
                .busy        (busy[gi]),
                .err_timeout (err_timeout[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/tl_xing_arbiter.md
TL_XING_ARBITER -- requirements
Module: tl_xing_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: cycles an outstanding request may wait for its D response before the timeout flag sets; legal range 1..65535.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_a_valid  in  2  A-channel valid, bit i = requester i.
REQ-005 req_a_ready  out  2  A-channel ready per requester.
REQ-006 req_a_opcode / req_a_address / req_a_data  in  6 / 18 / 64  A payload; requester i occupies slice i.
REQ-007 req_d_valid  out  2  D-channel valid per requester.
REQ-008 req_d_ready  in  2  D-channel ready per requester.
REQ-009 req_d_opcode, param, size, sink, denied, data, corrupt  out  3, 2, 2, 1, 1, 32, 1  D payload broadcast to both requesters; qualified by req_d_valid.
REQ-010 out_a_valid / out_a_ready  out / in  1 / 1  A handshake to the async crossing source enqueue side.
REQ-011 out_a_opcode, address, data, source  out  3, 9, 32, 1  A payload; source = granted requester index.
REQ-012 out_d_valid / out_d_ready  in / out  1 / 1  D handshake from the crossing source dequeue side.
REQ-013 out_d_opcode, param, size, source, sink, denied, data, corrupt  in  3, 2, 2, 1, 1, 1, 32, 1  D payload.
REQ-014 err_timeout  out  2  sticky per-requester timeout flag.
REQ-015 err_unexpected_d  out  1  sticky flag: D beat arrived for a requester with nothing outstanding.
REQ-016 err_clear  in  1  single-cycle pulse that clears all sticky error flags.

Function
REQ-017 Each requester has a 2-state tracker: IDLE -> BUSY on its A handshake (out_a_valid & out_a_ready while it holds the grant); BUSY -> IDLE on D handshake with out_d_source == i.
REQ-018 Only requesters in IDLE and asserting req_a_valid are eligible; at most one outstanding transaction per requester.
REQ-019 Arbitration is round-robin. A pointer names the priority requester and flips to the other index after each A handshake. With one eligible requester, that requester is granted.
REQ-020 The grant is locked while out_a_valid & !out_a_ready. The payload and the granted index stay stable until the handshake completes. Re-arbitration occurs only in a cycle without a locked grant.
REQ-021 out_a_valid = any eligible requester or a locked grant. out_a_* payload = the granted requester's slice. req_a_ready[i] = grant==i & out_a_ready. This path is combinational, with zero added latency.
REQ-022 D routing is combinational:
  - req_d_valid[i] = out_d_valid & out_d_source==i & BUSY[i]
  - out_d_ready = req_d_ready[out_d_source] when the addressed tracker is BUSY, else 1.
REQ-023 A D beat to an IDLE tracker is dropped: it is accepted, not forwarded, and sets err_unexpected_d.
REQ-024 Simultaneous completion of requester i's D and a new A from requester i in the same cycle is impossible, since the requester is ineligible while BUSY. The tracker returns to IDLE first; the requester can be granted from the next cycle.
REQ-025 Each requester has a 16-bit wait counter:
  - clears on the IDLE->BUSY transition and increments each BUSY cycle, saturating at 0xFFFF.
  - when it reaches TIMEOUT_CYCLES, err_timeout[i] sets; the tracker stays BUSY.
REQ-026 err_clear clears the sticky flags. A set event in the same cycle as err_clear wins (the flag stays 1).

Reset
REQ-027 On reset:
  - trackers go to IDLE, the round-robin pointer to 0, counters to 0, error flags to 0.
  - out_a_valid=0, req_d_valid=0, req_a_ready=0, out_d_ready=1.
REQ-028 Reset mid-transaction abandons outstanding state. D beats arriving after reset are flagged by err_unexpected_d.

Structure
REQ-029 A shared package holds: the A/D field-width constants (3/9/32/2/2), the tracker state enum {IDLE, BUSY}, and the requester-count constant 2.
REQ-030 One sub-module, tl_xing_req_tracker, is instantiated per requester. It contains the BUSY state, the wait counter and the timeout flag.

Verification
REQ-031 Both requesters valid, out_a_ready=1 -> grants alternate 0 then 1 on consecutive cycles; out_a_source = 0, then 1.
REQ-032 Requester 0 granted with out_a_ready=0 for 3 cycles while requester 1 asserts valid -> address, data and source stay at requester 0 values until the handshake on cycle 4.
REQ-033 D beat with source=1, data 0xDEADBEEF, req_d_ready[1]=0 for 2 cycles -> out_d_ready=0 for 2 cycles; req_d_valid=2'b10; tracker 1 returns to IDLE after the handshake.
REQ-034 D beat with source=0 while tracker 0 is IDLE -> accepted in 1 cycle, req_d_valid=0, err_unexpected_d=1 until err_clear.
REQ-035 TIMEOUT_CYCLES=8, no D after requester 1's A handshake -> err_timeout[1] rises on BUSY cycle 8; a later D clears BUSY but the flag stays set.
REQ-036 Reset asserted while both trackers are BUSY -> the next cycle shows both IDLE, the pointer at 0, out_a_valid=0 and all flags 0.
